// File: rtl/detector_fsm.sv
// rtl/detector_fsm.sv - serial key detector with sticky ISOLATION/DEADLOCK tamper locks
module detector_fsm (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out
);

    typedef enum logic [1:0] {
        SEARCH    = 2'd0,
        ISOLATION = 2'd1,
        DEADLOCK  = 2'd2
    } mode_t;

    mode_t      mode;
    logic [3:0] progress;
    logic [3:0] history;
    logic [2:0] count;

    logic [3:0] next_history;
    logic [2:0] next_count;
    logic [3:0] next_progress;
    logic       key_done;
    logic       trap_iso;
    logic       trap_dead;

    // KMP transition table for key 000010010100; a completed key falls back to "00".
    always_comb begin
        next_progress = 4'd0;
        key_done      = 1'b0;
        case (progress)
            4'd0:  next_progress = in ? 4'd0 : 4'd1;
            4'd1:  next_progress = in ? 4'd0 : 4'd2;
            4'd2:  next_progress = in ? 4'd0 : 4'd3;
            4'd3:  next_progress = in ? 4'd0 : 4'd4;
            4'd4:  next_progress = in ? 4'd5 : 4'd4;
            4'd5:  next_progress = in ? 4'd0 : 4'd6;
            4'd6:  next_progress = in ? 4'd0 : 4'd7;
            4'd7:  next_progress = in ? 4'd8 : 4'd3;
            4'd8:  next_progress = in ? 4'd0 : 4'd9;
            4'd9:  next_progress = in ? 4'd10 : 4'd2;
            4'd10: next_progress = in ? 4'd0 : 4'd11;
            4'd11: begin
                next_progress = in ? 4'd0 : 4'd2;
                key_done      = ~in;
            end
            default: next_progress = 4'd0;
        endcase
    end

    always_comb begin
        next_history = {history[2:0], in};
        next_count   = (count == 3'd4) ? 3'd4 : count + 3'd1;
        trap_iso     = (next_count == 3'd4) && (next_history == 4'b0110);
        trap_dead    = (next_count == 3'd4) && (next_history == 4'b0111);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode     <= SEARCH;
            progress <= 4'd0;
            history  <= 4'd0;
            count    <= 3'd0;
            out      <= 1'b0;
        end else begin
            case (mode)
                SEARCH: begin
                    history  <= next_history;
                    count    <= next_count;
                    progress <= next_progress;
                    // Traps win over a simultaneous key completion.
                    if (trap_iso) begin
                        mode <= ISOLATION;
                        out  <= 1'b0;
                    end else if (trap_dead) begin
                        mode <= DEADLOCK;
                        out  <= 1'b0;
                    end else begin
                        out <= key_done;
                    end
                end
                default: begin
                    out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_detector_fsm.sv
// tb/tb_detector_fsm.sv - directed and randomized checks of detector_fsm against a bit-history model
module tb_detector_fsm;

    logic clk;
    logic rst;
    logic in;
    logic out;

    int tests;
    int fails;
    int pulses;

    localparam logic [11:0] KEY = 12'b000010010100;

    // Reference model: the raw bits since reset plus a lock flag.
    bit m_bits[$];
    int m_locked;
    bit m_exp;

    detector_fsm dut (
        .clk(clk),
        .rst(rst),
        .in (in),
        .out(out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_step(input bit r, input bit b);
        logic [3:0]  last4;
        logic [11:0] last12;
        int n;
        if (r) begin
            m_bits.delete();
            m_locked = 0;
            m_exp    = 1'b0;
        end else if (m_locked != 0) begin
            m_exp = 1'b0;
        end else begin
            m_bits.push_back(b);
            if (m_bits.size() > 12) void'(m_bits.pop_front());
            n = m_bits.size();
            last4  = '0;
            last12 = '0;
            for (int i = 0; i < 4 && i < n; i++) last4[i] = m_bits[n-1-i];
            for (int i = 0; i < 12 && i < n; i++) last12[i] = m_bits[n-1-i];
            m_exp = 1'b0;
            if (n >= 4 && last4 == 4'b0110) m_locked = 1;
            else if (n >= 4 && last4 == 4'b0111) m_locked = 2;
            else m_exp = (n >= 12) && (last12 == KEY);
        end
    endtask

    task automatic step(input bit r, input bit b, input string tag);
        @(negedge clk);
        rst = r;
        in  = b;
        @(posedge clk);
        #1;
        model_step(r, b);
        tests++;
        assert (out === m_exp) else begin
            fails++;
            $error("FAIL %s out=%0b expected=%0b", tag, out, m_exp);
        end
        if (out === 1'b1) pulses++;
    endtask

    task automatic drive_bits(input logic [31:0] bits, input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) step(1'b0, bits[i], tag);
    endtask

    task automatic do_reset(input string tag);
        step(1'b1, 1'b0, tag);
        pulses = 0;
    endtask

    task automatic check_pulses(input int expv, input string tag);
        tests++;
        assert (pulses === expv) else begin
            fails++;
            $error("FAIL %s pulses=%0d expected=%0d", tag, pulses, expv);
        end
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        pulses = 0;
        m_locked = 0;
        m_exp  = 1'b0;
        rst = 1'b1;
        in  = 1'b0;

        do_reset("reset");
        step(1'b1, 1'b1, "reset_in_ignored");
        pulses = 0;

        drive_bits({20'd0, KEY}, 12, "basic");
        step(1'b0, 1'b1, "basic_after");
        check_pulses(1, "basic_pulses");

        do_reset("iso_rst");
        drive_bits(32'b011000, 6, "iso_trap");
        drive_bits({20'd0, KEY}, 12, "iso_key");
        check_pulses(0, "iso_pulses");
        do_reset("iso_recover_rst");
        drive_bits({20'd0, KEY}, 12, "iso_recover");
        check_pulses(1, "iso_recover_pulses");

        pulses = 0;
        drive_bits(32'b11111, 5, "dead_trap");
        drive_bits({20'd0, KEY}, 12, "dead_key");
        check_pulses(0, "dead_pulses");
        do_reset("dead_rst");
        drive_bits(32'b111, 3, "dead_three_ones");
        drive_bits({20'd0, KEY}, 12, "dead_recover_key");
        check_pulses(1, "dead_recover_pulses");

        do_reset("ovl_rst");
        drive_bits({17'd0, 3'b000, KEY}, 15, "ovl_zeros");
        check_pulses(1, "ovl_zeros_pulses");
        do_reset("ovl2_rst");
        drive_bits({20'd0, KEY}, 12, "ovl_b2b_a");
        drive_bits(32'b0010010100, 10, "ovl_b2b_b");
        check_pulses(2, "ovl_b2b_pulses");

        do_reset("mid_rst0");
        drive_bits({24'd0, KEY[11:4]}, 8, "mid_head");
        do_reset("mid_rst1");
        drive_bits({28'd0, KEY[3:0]}, 4, "mid_tail");
        check_pulses(0, "mid_tail_pulses");
        drive_bits({20'd0, KEY}, 12, "mid_full");
        check_pulses(1, "mid_full_pulses");

        do_reset("part_rst");
        drive_bits(32'b0000110, 7, "part_trap");
        drive_bits({20'd0, KEY}, 12, "part_key");
        drive_bits({20'd0, KEY}, 12, "part_key2");
        check_pulses(0, "part_pulses");

        do_reset("rand_rst");
        for (int i = 0; i < 3000; i++) begin
            int sel;
            sel = int'($urandom_range(0, 99));
            if (sel < 3) begin
                step(1'b1, 1'($urandom), "rand_reset");
            end else if (sel < 10) begin
                drive_bits({20'd0, KEY}, 12, "rand_key");
            end else begin
                step(1'b0, ($urandom_range(0, 9) < 3), "rand_bit");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout tests=%0d", tests);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/detector_fsm.md
Name: detector_fsm

Overview:
- Serial-bit sequence detector for security monitoring. It samples one bit of `in` per clock and pulses `out` when the 12-bit key sequence 000010010100 has been received.
- It also watches for two tamper patterns. 0110 locks the block into ISOLATION; 0111 locks it into DEADLOCK.
- Both lock states are sticky. Only reset clears them.
- Sits directly on a serial input line, ahead of the unlock/authorisation logic.

Parameters:
- none. The key sequence and the trap patterns are fixed constants.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in   input  1  serial data bit, sampled on every rising edge while rst=0.
- out  output 1  registered match pulse.

Behaviour:
- Reset and clocking:
  - One clock. Reset is synchronous and active-high.
  - With rst=1 at a rising edge, the next state is: mode SEARCH, match progress 0, trap history cleared, valid-bit count 0, out=0.
  - `in` is ignored during a reset cycle.
  - Reset has priority over everything, including when asserted mid-sequence or in a lock state.
- Modes: SEARCH, ISOLATION, DEADLOCK.
- Bit order: bits are received first-to-last exactly as written. The key is 0,0,0,0,1,0,0,1,0,1,0,0.
- Match tracking (SEARCH only):
  - Match progress runs 0..11 and uses overlapping (KMP-style) tracking.
  - A mismatch falls back to the longest key prefix that is a suffix of the received bits. It does not always drop to 0; for example, five 0s leave progress at 4.
- Match output:
  - When the 12th key bit is sampled, out=1 for exactly the following cycle.
  - Progress then continues with overlap. The key's prefix/suffix overlap is "00", so progress becomes 2.
  - A back-to-back match is therefore possible 10 cycles later.
- Trap history:
  - A 4-bit history of sampled bits, plus a saturating count of bits sampled since reset (0..4).
  - A trap fires only when count=4, i.e. four real bits have been received. Bits from before reset never count.
- Trap transitions (evaluated on each sampled bit while in SEARCH):
  - Last 4 bits = 0110 → next mode ISOLATION.
  - Last 4 bits = 0111 → next mode DEADLOCK.
- Trap priority:
  - A trap takes priority over match progress.
  - The key contains no "11", so a trap and a match cannot complete on the same bit. The implementation still gives the trap priority if both are ever true.
- ISOLATION and DEADLOCK behaviour:
  - out held 0; `in` ignored; history frozen.
  - Leaves the state only via rst=1, which returns the block to SEARCH.
  - A one-cycle reset pulse is sufficient.
- Shared history:
  - The trap history keeps updating during a partial key match.
  - Example: key prefix 00001 followed by 1,0 yields history 0110 → ISOLATION.
- Power-up: no reset-less initial value is relied on. The bench must assert rst before checking out.
- Output timing: out is a pure register (Moore-style). There is no combinational path from `in` to `out`.
- Expected size: roughly 150–250 lines of RTL.

Test Plan:
- Basic match: reset, then drive 000010010100 one bit per cycle → out=1 for exactly the one cycle after the last 0 is sampled, and 0 on every other cycle.
- Isolation trap and recovery:
  - Drive 0,1,1,0 then 0,0 → ISOLATION; out stays 0.
  - Then drive the full key → still out=0.
  - Pulse rst for one cycle, drive the key → out pulses once.
- Deadlock trap and recovery:
  - After a match, drive 1 five times → DEADLOCK entered on the third 1 (history 0111); out=0 throughout.
  - Pulse rst, drive 1,1,1 → no trap, since only three valid bits and the history is not 0111; out=0.
- Overlap:
  - Drive 000 followed by the key (15 bits) → out pulses once, showing correct fallback on extra 0s.
  - Drive the key followed by 0010010100 → two pulses 10 cycles apart.
- Reset mid-sequence: drive the first 8 key bits, assert rst one cycle, then drive the last 4 key bits → no pulse. A full key afterwards → pulse.
- Trap during a partial match: drive 00001 then 1,0 → ISOLATION. Completing any later bits produces no out pulse until reset.
